// File: rtl/rvv_seq_pkg.sv
// Shared definitions for the vector lane sequencer: widths, SEW codes, FSM states
// and the vlmax / chunk-count helpers used when an op is accepted.
package rvv_seq_pkg;

    localparam int IDX_W  = 11;
    localparam int PART_W = 4;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_e;

    function automatic logic [IDX_W-1:0] calc_vlmax(input int vlen, input logic [1:0] sew);
        return IDX_W'(vlen >> (int'(sew) + 3));
    endfunction

    // Highest chunk offset: an element wider than a lane is split into 2^(sew_log-lane_width) parts.
    function automatic logic [PART_W-1:0] calc_part_max(input logic [1:0] sew, input int lane_width);
        int sew_log;
        sew_log = int'(sew) + 3;
        if (sew_log > lane_width)
            return PART_W'((1 << (sew_log - lane_width)) - 1);
        return '0;
    endfunction

endpackage

// File: rtl/rvv_lane_idx_gen.sv
// Per-lane element index, bounds check against eff_vl and v0 mask gating.
// Purely combinational; one instance per lane.
module rvv_lane_idx_gen
    import rvv_seq_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int LANE = 0
) (
    input  logic [IDX_W-1:0] i_base,
    input  logic [IDX_W-1:0] i_eff_vl,
    input  logic             i_mask_en,
    input  logic [VLEN-1:0]  i_v0_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_active
);

    localparam int               MW       = $clog2(VLEN);
    localparam logic [IDX_W-1:0] LANE_OFF = IDX_W'(LANE);

    logic w_mask_bit;

    assign o_idx   = i_base + LANE_OFF;
    assign o_valid = (o_idx < i_eff_vl);
    // Out-of-range lanes may alias a mask bit, but o_valid already kills them.
    assign w_mask_bit = i_v0_mask[o_idx[MW-1:0]];
    assign o_active   = o_valid & (~i_mask_en | w_mask_bit);

endmodule

// File: rtl/rvv_lane_sequencer.sv
// Issues beats of NUM_LANES element indices (plus sub-element chunk offset) for one
// vector op at a time, with vl clamping, vstart, v0 masking and downstream stall.
module rvv_lane_sequencer
    import rvv_seq_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NUM_LANES  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 vsew,
    input  logic [IDX_W-1:0]           vl,
    input  logic [IDX_W-1:0]           vstart,
    input  logic                       mask_en,
    input  logic [VLEN-1:0]            v0_mask,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NUM_LANES-1:0]       lane_valid,
    output logic [NUM_LANES-1:0]       lane_active,
    output logic [IDX_W*NUM_LANES-1:0] lane_idx,
    output logic [PART_W-1:0]          part_idx,
    output logic                       last
);

    localparam logic [IDX_W-1:0] LANES_IDX = IDX_W'(NUM_LANES);

    state_e                     r_state, w_state_next;
    logic [IDX_W-1:0]           r_base, w_base_next;
    logic [PART_W-1:0]          r_part, w_part_next;
    logic [IDX_W-1:0]           r_eff_vl, w_eff_vl_next;
    logic [PART_W-1:0]          r_part_max, w_part_max_next;
    logic                       r_mask_en, w_mask_en_next;
    logic [VLEN-1:0]            r_v0_mask, w_v0_mask_next;

    logic [IDX_W-1:0]           w_vlmax;
    logic [IDX_W-1:0]           w_req_eff_vl;
    logic                       w_done_next;
    logic                       w_err_next;
    logic                       w_run_next;
    logic                       w_last_next;
    logic [NUM_LANES-1:0]       w_valid;
    logic [NUM_LANES-1:0]       w_active;
    logic [IDX_W*NUM_LANES-1:0] w_idx;

    logic                       r_busy;
    logic                       r_done;
    logic                       r_err;
    logic                       r_last;
    logic [NUM_LANES-1:0]       r_lane_valid;
    logic [NUM_LANES-1:0]       r_lane_active;
    logic [IDX_W*NUM_LANES-1:0] r_lane_idx;
    logic [PART_W-1:0]          r_part_idx;

    assign w_vlmax      = calc_vlmax(VLEN, vsew[1:0]);
    assign w_req_eff_vl = (vl < w_vlmax) ? vl : w_vlmax;

    always_comb begin
        w_state_next    = r_state;
        w_base_next     = r_base;
        w_part_next     = r_part;
        w_eff_vl_next   = r_eff_vl;
        w_part_max_next = r_part_max;
        w_mask_en_next  = r_mask_en;
        w_v0_mask_next  = r_v0_mask;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_eff_vl_next   = w_req_eff_vl;
                    w_part_max_next = calc_part_max(vsew[1:0], LANE_WIDTH);
                    w_mask_en_next  = mask_en;
                    w_v0_mask_next  = v0_mask;
                    w_base_next     = vstart;
                    w_part_next     = '0;
                    if (vsew[2]) begin
                        w_state_next = ERR;
                        w_err_next   = 1'b1;
                    end else if (vstart >= w_req_eff_vl) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                // A stalled beat keeps every next-value equal to the current one,
                // so the registered beat outputs are recomputed bit-identically.
                if (!stall) begin
                    if (r_last) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end else if (r_part == r_part_max) begin
                        w_part_next = '0;
                        w_base_next = r_base + LANES_IDX;
                    end else begin
                        w_part_next = r_part + PART_W'(1);
                    end
                end
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_run_next  = (w_state_next == RUN);
        w_last_next = w_run_next
                    && ((w_base_next + LANES_IDX) >= w_eff_vl_next)
                    && (w_part_next == w_part_max_next);
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        rvv_lane_idx_gen #(
            .VLEN (VLEN),
            .LANE (gi)
        ) u_idx_gen (
            .i_base    (w_base_next),
            .i_eff_vl  (w_eff_vl_next),
            .i_mask_en (w_mask_en_next),
            .i_v0_mask (w_v0_mask_next),
            .o_idx     (w_idx[gi*IDX_W +: IDX_W]),
            .o_valid   (w_valid[gi]),
            .o_active  (w_active[gi])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_part        <= '0;
            r_eff_vl      <= '0;
            r_part_max    <= '0;
            r_mask_en     <= 1'b0;
            r_v0_mask     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_last        <= 1'b0;
            r_lane_valid  <= '0;
            r_lane_active <= '0;
            r_lane_idx    <= '0;
            r_part_idx    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_base        <= w_base_next;
            r_part        <= w_part_next;
            r_eff_vl      <= w_eff_vl_next;
            r_part_max    <= w_part_max_next;
            r_mask_en     <= w_mask_en_next;
            r_v0_mask     <= w_v0_mask_next;
            r_busy        <= w_run_next;
            r_done        <= w_done_next;
            r_err         <= w_err_next;
            r_last        <= w_last_next;
            r_lane_valid  <= w_run_next ? w_valid : '0;
            r_lane_active <= w_run_next ? w_active : '0;
            r_lane_idx    <= w_run_next ? w_idx : '0;
            r_part_idx    <= w_run_next ? w_part_next : '0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign last        = r_last;
    assign lane_valid  = r_lane_valid;
    assign lane_active = r_lane_active;
    assign lane_idx    = r_lane_idx;
    assign part_idx    = r_part_idx;

endmodule

// File: tb/tb_rvv_lane_sequencer.sv
// Directed scoreboard bench for rvv_lane_sequencer (VLEN=128, 8-bit lanes, 4 lanes).
module tb_rvv_lane_sequencer;

    localparam int VLEN = 128;
    localparam int NL   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    vsew;
    logic [10:0]   vl;
    logic [10:0]   vstart;
    logic          mask_en;
    logic [127:0]  v0_mask;
    logic          stall;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    lane_valid;
    logic [3:0]    lane_active;
    logic [43:0]   lane_idx;
    logic [3:0]    part_idx;
    logic          last;

    rvv_lane_sequencer #(
        .VLEN       (VLEN),
        .LANE_WIDTH (3),
        .NUM_LANES  (NL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .vsew        (vsew),
        .vl          (vl),
        .vstart      (vstart),
        .mask_en     (mask_en),
        .v0_mask     (v0_mask),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .lane_valid  (lane_valid),
        .lane_active (lane_active),
        .lane_idx    (lane_idx),
        .part_idx    (part_idx),
        .last        (last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [43:0] idx;
        logic [3:0]  valid;
        logic [3:0]  active;
        logic [3:0]  part;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: kind 0 = beats expected, 1 = immediate done, 2 = illegal SEW.
    task automatic push_model(input logic [2:0] vs, input int vlv, input int vst,
                              input logic men, input logic [127:0] m, output int kind);
        int vlmax;
        int eff;
        int chunks;
        if (vs > 3'd3) begin
            kind = 2;
            return;
        end
        vlmax  = VLEN >> (int'(vs) + 3);
        eff    = (vlv < vlmax) ? vlv : vlmax;
        chunks = 1 << int'(vs);
        if (vst >= eff) begin
            kind = 1;
            return;
        end
        kind = 0;
        for (int b = vst; b < eff; b += NL) begin
            for (int p = 0; p < chunks; p++) begin
                beat_t e;
                e = '0;
                for (int i = 0; i < NL; i++) begin
                    int x;
                    x = b + i;
                    e.idx[i*11 +: 11] = 11'(x);
                    if (x < eff) begin
                        e.valid[i]  = 1'b1;
                        e.active[i] = !men || m[x];
                    end
                end
                e.part = 4'(p);
                e.last = (b + NL >= eff) && (p == chunks - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] vs, input int vlv, input int vst,
                         input logic men, input logic [127:0] m,
                         input int stall_beat, input int stall_len, input int dup_beat);
        int    kind;
        int    beat_n;
        int    stalled;
        int    cyc;
        beat_t obs;
        push_model(vs, vlv, vst, men, m, kind);
        @(negedge clk);
        start   = 1'b1;
        vsew    = vs;
        vl      = 11'(vlv);
        vstart  = 11'(vst);
        mask_en = men;
        v0_mask = m;
        stall   = 1'b1;
        @(negedge clk);
        // Scramble config so any non-latched use shows up.
        start   = 1'b0;
        stall   = 1'b0;
        vsew    = 3'd5;
        vl      = 11'd1;
        vstart  = 11'd0;
        mask_en = ~men;
        v0_mask = ~m;
        if (kind == 2) begin
            check({name, " err"}, {busy, done, err, lane_valid}, {3'b001, 4'b0000});
            @(negedge clk);
            check({name, " err_end"}, {busy, done, err, lane_valid}, 7'd0);
            return;
        end
        if (kind == 1) begin
            check({name, " empty_done"}, {busy, done, err, lane_valid}, {3'b010, 4'b0000});
            @(negedge clk);
            check({name, " empty_end"}, {busy, done, err, lane_valid}, 7'd0);
            return;
        end
        beat_n  = 0;
        stalled = 0;
        cyc     = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            obs = {lane_idx, lane_valid, lane_active, part_idx, last};
            check($sformatf("%s beat%0d", name, beat_n), {busy, done, err, obs}, {3'b100, exp_q[0]});
            start = (beat_n == dup_beat);
            if (beat_n == stall_beat && stalled < stall_len) begin
                stall = 1'b1;
                stalled++;
            end else begin
                stall = 1'b0;
                void'(exp_q.pop_front());
                beat_n++;
            end
            cyc++;
            @(negedge clk);
        end
        stall = 1'b0;
        start = (dup_beat >= 0);
        if (exp_q.size() > 0) begin
            check({name, " timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        check({name, " done"}, {busy, done, err, lane_valid, last}, {3'b010, 4'b0000, 1'b0});
        @(negedge clk);
        start = 1'b0;
        check({name, " idle"}, {busy, done, err, lane_valid}, 7'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        vsew    = 3'd0;
        vl      = 11'd0;
        vstart  = 11'd0;
        mask_en = 1'b0;
        v0_mask = '0;
        stall   = 1'b0;
        @(negedge clk);
        check("reset", {busy, done, err, lane_valid, lane_active, lane_idx, part_idx, last}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("sew8_vl16",    3'd0, 16, 0, 1'b0, '0, -1, 0, 1);
        do_op("sew32_vl4",    3'd2, 4,  0, 1'b0, '0, -1, 0, -1);
        do_op("sew8_vl6",     3'd0, 6,  0, 1'b0, '0, -1, 0, -1);
        do_op("sew8_clamp",   3'd0, 40, 0, 1'b0, '0, -1, 0, -1);
        do_op("vstart5",      3'd0, 6,  5, 1'b0, '0, -1, 0, -1);
        do_op("vstart7",      3'd0, 6,  7, 1'b0, '0, -1, 0, -1);
        do_op("mask0101",     3'd0, 4,  0, 1'b1, 128'h5, -1, 0, -1);
        do_op("sew_illegal",  3'd5, 4,  0, 1'b0, '0, -1, 0, -1);
        do_op("sew64_vl2",    3'd3, 2,  0, 1'b0, '0, -1, 0, -1);
        do_op("sew16_vst3",   3'd1, 20, 3, 1'b0, '0, -1, 0, -1);
        do_op("mask_rand",    3'd0, 16, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0, -1);
        do_op("stall3",       3'd0, 16, 0, 1'b0, '0, 1, 3, -1);

        // Reset in the middle of an op: outputs clear at once and no done follows.
        @(negedge clk);
        start  = 1'b1;
        vsew   = 3'd0;
        vl     = 11'd16;
        vstart = 11'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", {busy, lane_valid}, 5'b11111);
        reset = 1'b1;
        #1;
        check("mid_reset", {busy, done, err, lane_valid, lane_active, lane_idx, part_idx, last}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", i), {busy, done, err, lane_valid}, 7'd0);
        end

        do_op("after_reset",  3'd0, 8,  0, 1'b0, '0, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
